wb_port_arbiter: RTL

- Round-robin arbiter that shares one register-file write port between NUM_REQ writeback requesters (e.g. SALU, SIMD, SIMF, LSU).
- Selects one requester per cycle, acks it, and drives a registered write strobe, address and data.
- Those outputs feed the enable/d inputs of the enable-gated flop bank that holds the register file.
- Supports locked multi-beat bursts, with a starvation limit.

---
 rtl/wb_port_arbiter.sv | 135 +++++++++++++
 1 files changed

// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter sharing one register-file write port between NUM_REQ writeback
// requesters, with locked bursts bounded by MAX_HOLD consecutive beats while others wait.
//  state    | meaning
//  S_IDLE   | no lock held; every cycle is a plain round-robin pick
//  S_LOCKED | r_owner holds the port for a burst, bounded by r_hold_cnt
module wb_port_arbiter #(
   parameter int NUM_REQ  = 4,
   parameter int ADDR_W   = 9,
   parameter int DATA_W   = 32,
   parameter int MAX_HOLD = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ-1:0]        lock,
   input  logic [NUM_REQ*ADDR_W-1:0] addr_in,
   input  logic [NUM_REQ*DATA_W-1:0] data_in,
   output logic [NUM_REQ-1:0]        ack,
   output logic                      wr_en,
   output logic [ADDR_W-1:0]         wr_addr,
   output logic [DATA_W-1:0]         wr_data,
   output logic                      busy
);

   localparam int PTR_W  = $clog2(NUM_REQ);
   localparam int HOLD_W = $clog2(MAX_HOLD + 1);

   localparam logic [0:0] S_IDLE   = 1'b0;
   localparam logic [0:0] S_LOCKED = 1'b1;

   logic [0:0]        r_state;
   logic [PTR_W-1:0]  r_ptr;
   logic [PTR_W-1:0]  r_owner;
   logic [HOLD_W-1:0] r_hold_cnt;
   logic              r_wr_en;
   logic [ADDR_W-1:0] r_wr_addr;
   logic [DATA_W-1:0] r_wr_data;
   logic              r_busy;

   logic [NUM_REQ-1:0] w_owner_oh;
   logic [NUM_REQ-1:0] w_mask;
   logic [PTR_W-1:0]   w_start;
   logic [PTR_W-1:0]   w_win;
   logic [PTR_W-1:0]   w_sel;
   logic               w_own_hold;
   logic               w_others;
   logic               w_keep;
   logic               w_found;
   logic               w_grant;
   logic [0:0]         w_state_nxt;
   logic [ADDR_W-1:0]  w_addr;
   logic [DATA_W-1:0]  w_data;

   function automatic logic [PTR_W-1:0] inc_mod(input logic [PTR_W-1:0] v);
      return (v == PTR_W'(NUM_REQ - 1)) ? '0 : v + PTR_W'(1);
   endfunction

   always_comb begin : p_select
      int idx;
      idx         = 0;
      w_owner_oh  = NUM_REQ'(1) << r_owner;
      w_own_hold  = (r_state == S_LOCKED) && req[r_owner] && lock[r_owner];
      w_others    = |(req & ~w_owner_oh);
      w_keep      = w_own_hold && ((r_hold_cnt < HOLD_W'(MAX_HOLD)) || !w_others);
      // Only reached with w_own_hold when the limit forces a hand-off: skip the owner.
      w_mask      = w_own_hold ? (req & ~w_owner_oh) : req;
      w_start     = w_own_hold ? inc_mod(r_owner) : r_ptr;
      w_found     = 1'b0;
      w_win       = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = int'(w_start) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!w_found && w_mask[idx]) begin
            w_found = 1'b1;
            w_win   = PTR_W'(idx);
         end
      end
      w_sel   = w_keep ? r_owner : w_win;
      w_grant = !rst && (w_keep || w_found);
      ack     = w_grant ? (NUM_REQ'(1) << w_sel) : '0;

      if (w_keep)
         w_state_nxt = S_LOCKED;
      else if (w_found)
         w_state_nxt = lock[w_win] ? S_LOCKED : S_IDLE;
      else
         w_state_nxt = ((r_state == S_LOCKED) && lock[r_owner]) ? S_LOCKED : S_IDLE;

      w_addr = '0;
      w_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_sel == PTR_W'(i)) begin
            w_addr = addr_in[i*ADDR_W +: ADDR_W];
            w_data = data_in[i*DATA_W +: DATA_W];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_ptr      <= '0;
         r_owner    <= '0;
         r_hold_cnt <= '0;
         r_wr_en    <= 1'b0;
         r_wr_addr  <= '0;
         r_wr_data  <= '0;
         r_busy     <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_busy  <= (w_state_nxt == S_LOCKED);
         r_wr_en <= w_grant;
         if (w_grant) begin
            r_wr_addr <= w_addr;
            r_wr_data <= w_data;
         end
         if (w_keep) begin
            if (r_hold_cnt != HOLD_W'(MAX_HOLD))
               r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
         end else if (w_found) begin
            r_ptr <= inc_mod(w_win);
            if (lock[w_win]) begin
               r_owner    <= w_win;
               r_hold_cnt <= HOLD_W'(1);
            end
         end
      end
   end

   assign wr_en   = r_wr_en;
   assign wr_addr = r_wr_addr;
   assign wr_data = r_wr_data;
   assign busy    = r_busy;

endmodule
